// File: rtl/fast_fp_fma_stream.sv
// rtl/fast_fp_fma_stream.sv - streaming fixed-point fused multiply-add with elastic pipeline
package ransac_fixed;
  typedef enum logic [1:0] {
    FMA_OPCODE_POS_A_POS_C = 2'd0,
    FMA_OPCODE_POS_A_NEG_C = 2'd1,
    FMA_OPCODE_NEG_A_POS_C = 2'd2,
    FMA_OPCODE_NEG_A_NEG_C = 2'd3
  } fma_opcode_t;
endpackage

module fast_fp_fma_stream #(
  parameter int VALUE_BITS    = 32,
  parameter int FRACTION_BITS = 16,
  parameter int MUL_STAGES    = 4,
  parameter int ROUND_NEAREST = 1,
  parameter int SATURATE      = 1,
  parameter int TAG_BITS      = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  ransac_fixed::fma_opcode_t opcode,
  input  logic [VALUE_BITS-1:0]     a,
  input  logic [VALUE_BITS-1:0]     b,
  input  logic [VALUE_BITS-1:0]     c,
  input  logic [TAG_BITS-1:0]       tag_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VALUE_BITS-1:0]     r,
  output logic                      overflow,
  output logic [TAG_BITS-1:0]       tag_o,
  output logic                      busy
);
  import ransac_fixed::*;

  localparam int W  = VALUE_BITS;
  localparam int M  = MUL_STAGES;
  localparam int PW = 2 * W;   // full product width
  localparam int EW = W + 2;   // rescaled-product / extended-c width
  localparam int SW = W + 3;   // sum width: one guard bit so a clamped product plus c never wraps

  localparam logic signed [PW-1:0] RND_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] RND     = (ROUND_NEAREST != 0) ? (RND_ONE <<< (FRACTION_BITS-1)) : '0;
  localparam logic signed [PW-1:0] P_EMAX  = {{(PW-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [PW-1:0] P_EMIN  = {{(PW-EW+1){1'b1}}, {(EW-1){1'b0}}};
  localparam logic signed [SW-1:0] S_RMAX  = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] S_RMIN  = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  // Multiply stages: stage 0 forms the signed product, later stages are delay slots for retiming.
  logic [M-1:0]            valid_q, valid_d;
  logic signed [PW-1:0]    prod_q [M];
  logic signed [PW-1:0]    prod_d [M];
  logic signed [EW-1:0]    cext_q [M];
  logic signed [EW-1:0]    cext_d [M];
  logic [TAG_BITS-1:0]     tagp_q [M];
  logic [TAG_BITS-1:0]     tagp_d [M];

  // Output stage (add / round / saturate).
  logic                    out_valid_q, out_valid_d;
  logic [W-1:0]            r_q, r_d;
  logic                    ovf_q, ovf_d;
  logic [TAG_BITS-1:0]     tag_o_q, tag_o_d;

  logic [M:0]              ready;
  logic                    full;
  logic signed [PW-1:0]    prod_full;
  logic signed [EW-1:0]    c_full;
  logic                    neg_a, neg_c;
  logic signed [PW-1:0]    p_rnd, p_sh;
  logic signed [EW-1:0]    p_cl;
  logic                    ovf_p;
  logic signed [SW-1:0]    sum_w;
  logic [W-1:0]            res_r;
  logic                    res_ovf;

  // Ready chain: a stage may load if it, or any stage after it, has room (bubble collapsing).
  always_comb begin
    ready    = '0;
    full     = 1'b0;
    ready[M] = !out_valid_q | out_ready;
    for (int k = 0; k < M; k++) begin
      full = 1'b1;
      for (int j = k; j < M; j++) full &= valid_q[j];
      ready[k] = !full | ready[M];
    end
  end

  // Stage 0 operand conditioning: exact wide product and extended addend with opcode signs.
  always_comb begin
    prod_full = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    c_full    = $signed({{2{c[W-1]}}, c});
    neg_a     = (opcode == FMA_OPCODE_NEG_A_POS_C) || (opcode == FMA_OPCODE_NEG_A_NEG_C);
    neg_c     = (opcode == FMA_OPCODE_POS_A_NEG_C) || (opcode == FMA_OPCODE_NEG_A_NEG_C);
  end

  // Final stage arithmetic: round, rescale, clamp, add, then saturate or wrap.
  always_comb begin
    p_rnd = prod_q[M-1] + RND;
    p_sh  = p_rnd >>> FRACTION_BITS;
    ovf_p = 1'b0;
    if (p_sh > P_EMAX) begin
      p_cl  = P_EMAX[EW-1:0];
      ovf_p = 1'b1;
    end else if (p_sh < P_EMIN) begin
      p_cl  = P_EMIN[EW-1:0];
      ovf_p = 1'b1;
    end else begin
      p_cl  = p_sh[EW-1:0];
    end
    sum_w   = $signed({p_cl[EW-1], p_cl}) + $signed({cext_q[M-1][EW-1], cext_q[M-1]});
    res_ovf = ovf_p | (sum_w > S_RMAX) | (sum_w < S_RMIN);
    if (res_ovf && (SATURATE != 0)) res_r = sum_w[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                            res_r = sum_w[W-1:0];
  end

  // Next-state for every stage: hold when blocked, otherwise take the upstream slot (valid or bubble).
  always_comb begin
    valid_d     = valid_q;
    prod_d      = prod_q;
    cext_d      = cext_q;
    tagp_d      = tagp_q;
    out_valid_d = out_valid_q;
    r_d         = r_q;
    ovf_d       = ovf_q;
    tag_o_d     = tag_o_q;
    if (ready[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        prod_d[0] = neg_a ? -prod_full : prod_full;
        cext_d[0] = neg_c ? -c_full : c_full;
        tagp_d[0] = tag_i;
      end
    end
    for (int k = 1; k < M; k++) begin
      if (ready[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          prod_d[k] = prod_q[k-1];
          cext_d[k] = cext_q[k-1];
          tagp_d[k] = tagp_q[k-1];
        end
      end
    end
    if (ready[M]) begin
      out_valid_d = valid_q[M-1];
      if (valid_q[M-1]) begin
        r_d     = res_r;
        ovf_d   = res_ovf;
        tag_o_d = tagp_q[M-1];
      end
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      for (int k = 0; k < M; k++) begin
        prod_q[k] <= '0;
        cext_q[k] <= '0;
        tagp_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      tag_o_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      prod_q      <= prod_d;
      cext_q      <= cext_d;
      tagp_q      <= tagp_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      ovf_q       <= ovf_d;
      tag_o_q     <= tag_o_d;
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign overflow  = ovf_q;
  assign tag_o     = tag_o_q;
  assign busy      = (|valid_q) | out_valid_q;

endmodule
